// File: rtl/axi_mem_resp.sv
// axi_mem_resp: AXI4 slave memory responder with concurrent read/write bursts and an mtime read tap
module axi_mem_resp #(
  parameter logic [63:0] base = 64'h80000000,
  parameter int awd = 20,
  parameter logic [63:0] mtime_addr = 64'h0200bff8,
  parameter int rlat = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] mtime,
  input  logic [7:0]  s_axi_awid,
  input  logic [63:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awlock,
  input  logic [3:0]  s_axi_awcache,
  input  logic [2:0]  s_axi_awprot,
  input  logic [3:0]  s_axi_awqos,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [7:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [7:0]  s_axi_arid,
  input  logic [63:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arlock,
  input  logic [3:0]  s_axi_arcache,
  input  logic [2:0]  s_axi_arprot,
  input  logic [3:0]  s_axi_arqos,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [7:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        read_mtime,
  output logic [63:0] read_mtimeval
);
  localparam logic [63:0] lim = base + (64'd1 << (awd + 3));
  logic [63:0] mem [0:(1 << awd) - 1];
  logic unused;
  assign unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
  function automatic logic in_rng(input logic [63:0] a);
    return a >= base && a < lim;
  endfunction
  function automatic logic [awd-1:0] widx(input logic [63:0] a);
    return awd'((a - base) >> 3);
  endfunction
  // Reserved burst type falls through to INCR
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] inc, mask;
    inc = 64'd1 << size;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    return burst == 2'b00 ? a : burst == 2'b10 ? (a & ~mask) | ((a + inc) & mask) : a + inc;
  endfunction
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_t;
  w_st_t w_st, w_nxt;
  logic [63:0] w_addr;
  logic [7:0] w_len, w_cnt;
  logic [2:0] w_size;
  logic [1:0] w_burst;
  logic w_hs, w_ok;
  assign w_hs = s_axi_wready && s_axi_wvalid;
  assign w_ok = in_rng(w_addr);
  always_ff @(posedge clk) w_st <= rst ? W_IDLE : w_nxt;
  always_comb begin
    w_nxt = w_st;
    s_axi_awready = w_st == W_IDLE;
    s_axi_wready = w_st == W_DATA;
    s_axi_bvalid = w_st == W_RESP;
    if (s_axi_awready && s_axi_awvalid) w_nxt = W_DATA;
    if (w_hs && w_cnt == w_len) w_nxt = W_RESP;
    if (s_axi_bvalid && s_axi_bready) w_nxt = W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_bid <= '0;
      s_axi_bresp <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_size <= '0;
      w_burst <= '0;
    end else if (s_axi_awready && s_axi_awvalid) begin
      s_axi_bid <= s_axi_awid;
      s_axi_bresp <= 2'b00;
      w_addr <= s_axi_awaddr;
      w_len <= s_axi_awlen;
      w_cnt <= 8'd0;
      w_size <= s_axi_awsize;
      w_burst <= s_axi_awburst;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
      w_cnt <= w_cnt + 8'd1;
      if (!w_ok) s_axi_bresp <= 2'b11;
      else if (s_axi_wlast != (w_cnt == w_len) && s_axi_bresp != 2'b11) s_axi_bresp <= 2'b10;
    end
  end
  always_ff @(posedge clk)
    if (!rst && w_hs && w_ok)
      for (int i = 0; i < 8; i++)
        if (s_axi_wstrb[i]) mem[widx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_st_t;
  r_st_t r_st, r_nxt;
  logic [63:0] r_addr, ld_addr;
  logic [7:0] r_len, r_cnt, ld_cnt, ld_len;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic [3:0] r_wait;
  logic r_mt, ld, ld_ok, ld_mt, ar_hs;
  assign ar_hs = s_axi_arready && s_axi_arvalid;
  assign ld_ok = in_rng(ld_addr);
  assign ld_mt = ld_addr == mtime_addr;
  always_ff @(posedge clk) r_st <= rst ? R_IDLE : r_nxt;
  always_comb begin
    r_nxt = r_st;
    ld = 1'b0;
    ld_addr = r_addr;
    ld_cnt = r_cnt;
    ld_len = r_len;
    s_axi_arready = r_st == R_IDLE;
    s_axi_rvalid = r_st == R_DATA;
    case (r_st)
      R_IDLE: if (s_axi_arvalid) begin
        r_nxt = rlat == 0 ? R_DATA : R_WAIT;
        ld = rlat == 0;
        ld_addr = s_axi_araddr;
        ld_cnt = 8'd0;
        ld_len = s_axi_arlen;
      end
      R_WAIT: if (r_wait == 4'd1) begin
        r_nxt = R_DATA;
        ld = 1'b1;
      end
      R_DATA: if (s_axi_rready) begin
        r_nxt = s_axi_rlast ? R_IDLE : R_DATA;
        ld = !s_axi_rlast;
        ld_addr = next_addr(r_addr, r_len, r_size, r_burst);
        ld_cnt = r_cnt + 8'd1;
      end
      default: r_nxt = R_IDLE;
    endcase
  end
  // A beat is registered the cycle it is loaded, so a same-cycle write is not yet visible
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axi_rid <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= '0;
      s_axi_rlast <= 1'b0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_wait <= '0;
      r_mt <= 1'b0;
      read_mtime <= 1'b0;
      read_mtimeval <= '0;
    end else begin
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        r_addr <= s_axi_araddr;
        r_len <= s_axi_arlen;
        r_cnt <= 8'd0;
        r_size <= s_axi_arsize;
        r_burst <= s_axi_arburst;
        r_wait <= 4'(rlat);
      end else if (r_st == R_WAIT) r_wait <= r_wait - 4'd1;
      if (ld) begin
        r_addr <= ld_addr;
        r_cnt <= ld_cnt;
        s_axi_rdata <= ld_ok ? mem[widx(ld_addr)] : ld_mt ? mtime : 64'd0;
        s_axi_rresp <= ld_ok || ld_mt ? 2'b00 : 2'b11;
        s_axi_rlast <= ld_cnt == ld_len;
        r_mt <= !ld_ok && ld_mt;
      end
      read_mtime <= s_axi_rvalid && s_axi_rready && r_mt;
      if (s_axi_rvalid && s_axi_rready && r_mt) read_mtimeval <= s_axi_rdata;
    end
  end
endmodule

// File: tb/tb_axi_mem_resp.sv
// tb_axi_mem_resp: scoreboard bench for axi_mem_resp bursts, error responses, mtime tap and reset
module tb_axi_mem_resp;
  localparam logic [63:0] base_a = 64'h80000000;
  localparam logic [63:0] lim_a = 64'h80008000;
  localparam logic [63:0] mt_a = 64'h0200bff8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] mtime = '0;
  logic [7:0] awid = '0, arid = '0, awlen = '0, arlen = '0, wstrb = '0;
  logic [63:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0] awsize = 3'd3, arsize = 3'd3;
  logic [1:0] awburst = 2'b01, arburst = 2'b01;
  logic awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, bvalid, arready, rvalid, rlast, read_mtime;
  logic [7:0] bid, rid;
  logic [1:0] bresp, rresp;
  logic [63:0] rdata, read_mtimeval;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [63:0] d; logic [1:0] resp; logic last; logic [7:0] id;} beat_t;
  typedef struct {logic [63:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [3:0][63:0] ea;} rv_t;
  beat_t rq[$];
  logic [9:0] bq[$];
  beat_t e;
  logic [9:0] eb;
  logic [63:0] model [4096];
  rv_t tbl [8];

  axi_mem_resp #(.base(base_a), .awd(12), .mtime_addr(mt_a), .rlat(2)) dut (
    .clk(clk), .rst(rst), .mtime(mtime),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'd0), .s_axi_awprot(3'd0),
    .s_axi_awqos(4'd0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'd0), .s_axi_arprot(3'd0),
    .s_axi_arqos(4'd0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .read_mtime(read_mtime), .read_mtimeval(read_mtimeval)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic in_mem(input logic [63:0] a);
    return a >= base_a && a < lim_a;
  endfunction
  function automatic logic [63:0] exp_data(input logic [63:0] a);
    if (in_mem(a)) return model[int'((a - base_a) >> 3)];
    return a == mt_a ? mtime : 64'd0;
  endfunction
  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    return in_mem(a) || a == mt_a ? 2'b00 : 2'b11;
  endfunction

  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_extra actual=beat_%h required=none", rdata);
      end else begin
        e = rq.pop_front();
        chk("rdata", rdata, e.d);
        chk("rresp", 64'(rresp), 64'(e.resp));
        chk("rlast", 64'(rlast), 64'(e.last));
        chk("rid", 64'(rid), 64'(e.id));
      end
    end
    if (!rst && bvalid && bready) begin
      if (bq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_extra actual=resp_%b required=none", bresp);
      end else begin
        eb = bq.pop_front();
        chk("bid", 64'(bid), 64'(eb[9:2]));
        chk("bresp", 64'(bresp), 64'(eb[1:0]));
      end
    end
  end

  task automatic do_ar(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_hs", 64'(arready), 64'd1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_hs", 64'(awready), 64'd1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l, input logic [63:0] a);
    int n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin @(negedge clk); n++; end
    chk("w_hs", 64'(wready), 64'd1);
    if (in_mem(a))
      for (int k = 0; k < 8; k++)
        if (s[k]) model[int'((a - base_a) >> 3)][8*k +: 8] = d[8*k +: 8];
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() > 0 || bq.size() > 0) && n < 600) begin @(posedge clk); n++; end
    chk("drain_left", 64'(rq.size() + bq.size()), 64'd0);
    rq.delete();
    bq.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input int i);
    for (int j = 0; j <= int'(tbl[i].len); j++)
      rq.push_back('{exp_data(tbl[i].ea[j]), exp_resp(tbl[i].ea[j]), j == int'(tbl[i].len), 8'(i)});
    do_ar(8'(i), tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) begin
      model[i] = 64'(i + 1) ^ (64'(i) << 40);
      dut.mem[i] = model[i];
    end
    tbl[0] = '{64'h80000000, 8'd3, 3'd3, 2'b01, {64'h80000018, 64'h80000010, 64'h80000008, 64'h80000000}};
    tbl[1] = '{64'h80000018, 8'd3, 3'd3, 2'b10, {64'h80000010, 64'h80000008, 64'h80000000, 64'h80000018}};
    tbl[2] = '{64'h80000020, 8'd2, 3'd3, 2'b00, {64'h0, 64'h80000020, 64'h80000020, 64'h80000020}};
    tbl[3] = '{64'h10000000, 8'd1, 3'd3, 2'b01, {64'h0, 64'h0, 64'h10000008, 64'h10000000}};
    tbl[4] = '{64'h80000040, 8'd1, 3'd3, 2'b11, {64'h0, 64'h0, 64'h80000048, 64'h80000040}};
    tbl[5] = '{64'h80000104, 8'd1, 3'd2, 2'b10, {64'h0, 64'h0, 64'h80000100, 64'h80000104}};
    tbl[6] = '{64'h80007ff8, 8'd1, 3'd3, 2'b01, {64'h0, 64'h0, 64'h80008000, 64'h80007ff8}};
    tbl[7] = '{mt_a, 8'd0, 3'd3, 2'b01, {64'h0, 64'h0, 64'h0, mt_a}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_resp", 64'({bresp, rresp}), 64'd0);
    chk("rst_ids", 64'({bid, rid}), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mtime", 64'(read_mtime), 64'd0);
    chk("rst_mtimeval", read_mtimeval, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    mtime = 64'hfeed0000_00000042;
    for (int i = 0; i < 8; i++) begin
      run_vec(i);
      if (i == 0) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 20);
        chk("rd_first_lat", 64'(n), 64'd3);
      end
      drain();
    end
    bq.push_back({8'h21, 2'b00});
    do_aw(8'h21, 64'h80000008, 8'd1);
    do_w(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0, 64'h80000008);
    do_w(64'h1122334455667788, 8'h0F, 1'b1, 64'h80000010);
    @(negedge clk);
    chk("bvalid_lat", 64'(bvalid), 64'd1);
    drain();
    rq.push_back('{64'hAAAAAAAAAAAAAAAA, 2'b00, 1'b0, 8'h24});
    rq.push_back('{64'h0000020055667788, 2'b00, 1'b1, 8'h24});
    do_ar(8'h24, 64'h80000008, 8'd1, 3'd3, 2'b01);
    drain();
    bq.push_back({8'h22, 2'b11});
    do_aw(8'h22, 64'h10000000, 8'd0);
    do_w(64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 64'h10000000);
    drain();
    bq.push_back({8'h23, 2'b10});
    do_aw(8'h23, 64'h80000200, 8'd1);
    do_w(64'h0123456789ABCDEF, 8'hFF, 1'b1, 64'h80000200);
    do_w(64'hFEDCBA9876543210, 8'hFF, 1'b1, 64'h80000208);
    drain();
    for (int j = 0; j < 2; j++)
      rq.push_back('{exp_data(64'h80000200 + 64'(8 * j)), 2'b00, j == 1, 8'h25});
    do_ar(8'h25, 64'h80000200, 8'd1, 3'd3, 2'b01);
    drain();
    for (int j = 0; j < 256; j++)
      rq.push_back('{exp_data(base_a + 64'(8 * j)), 2'b00, j == 255, 8'h30});
    do_ar(8'h30, base_a, 8'd255, 3'd3, 2'b01);
    drain();
    mtime = 64'h1234;
    rready = 1'b0;
    rq.push_back('{64'h1234, 2'b00, 1'b1, 8'h40});
    do_ar(8'h40, mt_a, 8'd0, 3'd3, 2'b01);
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    for (int k = 0; k < 3; k++) begin
      chk("mt_hold_valid", 64'(rvalid), 64'd1);
      chk("mt_hold_data", rdata, 64'h1234);
      chk("mt_no_pulse", 64'(read_mtime), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("mt_pulse", 64'(read_mtime), 64'd1);
    chk("mt_val", read_mtimeval, 64'h1234);
    @(negedge clk);
    chk("mt_pulse_end", 64'(read_mtime), 64'd0);
    @(posedge clk); #1;
    do_aw(8'h50, 64'h80000300, 8'd3);
    for (int j = 0; j < 8; j++)
      rq.push_back('{exp_data(base_a + 64'(8 * j)), 2'b00, j == 7, 8'h51});
    do_ar(8'h51, base_a, 8'd7, 3'd3, 2'b01);
    n = 0;
    while (rq.size() > 6 && n < 50) begin @(posedge clk); n++; end
    chk("rst_mid_beats", 64'(rq.size()), 64'd6);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rq.delete();
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
    chk("mid_rst_wready", 64'(wready), 64'd0);
    chk("mid_rst_arready", 64'(arready), 64'd1);
    chk("mid_rst_awready", 64'(awready), 64'd1);
    chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
    @(posedge clk); #1;
    run_vec(0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
